// File: rtl/bwt_rotation_gen_pkg.sv
// Shared definitions for the BWT rotation generator.
//   BYTE_W      : width of one block character
//   bwt_state_e : LOAD / EMIT phase encoding
//   rot_idx     : (j + k) mod column for j, k < column, without a divider
package bwt_pkg;

  localparam int unsigned BYTE_W = 8;

  // Sparse encoding leaves unused codes that the FSM folds back to LOAD.
  typedef enum logic [1:0] {
    StLoad = 2'b01,
    StEmit = 2'b10
  } bwt_state_e;

  // j + k < 2*column, so a single conditional subtract is a full modulo.
  function automatic int unsigned rot_idx(input int unsigned j,
                                          input int unsigned k,
                                          input int unsigned column);
    int unsigned sum;
    sum = j + k;
    if (sum >= column) begin
      sum = sum - column;
    end
    return sum;
  endfunction

endpackage

// File: rtl/bwt_rotation_gen.sv
// Captures a block of COLUMN bytes, then emits all COLUMN cyclic rotations of it,
// one row per rot_valid/rot_ready handshake. Loading and emitting alternate.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_byte: input byte stream, first byte of a block is character 0
//   in_ready        : high while loading (LOAD state)
//   rot_row         : rotation row, element j = character j of rotation rot_index
//   rot_valid/ready : output handshake
//   rot_index       : rotation number k of the current row
//   rot_last        : high with the row for k = COLUMN-1
//   busy            : high while emitting (EMIT state)
module bwt_rotation_gen
  import bwt_pkg::*;
#(
  parameter int unsigned COLUMN = 3,
  parameter int unsigned IDX_W  = (COLUMN > 1) ? $clog2(COLUMN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_byte,
  output logic              in_ready,
  output logic [BYTE_W-1:0] rot_row [COLUMN],
  output logic              rot_valid,
  input  logic              rot_ready,
  output logic [IDX_W-1:0]  rot_index,
  output logic              rot_last,
  output logic              busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(COLUMN - 1);

  bwt_state_e        state_q, state_d;
  logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]  rot_cnt_q, rot_cnt_d;
  logic [BYTE_W-1:0] byte_buf_q [COLUMN];
  logic [BYTE_W-1:0] byte_buf_d [COLUMN];
  logic [BYTE_W-1:0] rot_row_q [COLUMN];
  logic [BYTE_W-1:0] rot_row_d [COLUMN];
  logic              rot_valid_q, rot_valid_d;
  logic              rot_last_q, rot_last_d;

  // Row build request: when load_row is set, the row registers take rotation row_k
  // of byte_buf_d (which already contains the byte being accepted this cycle).
  logic              load_row;
  logic [IDX_W-1:0]  row_k;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    rot_cnt_d   = rot_cnt_q;
    byte_buf_d  = byte_buf_q;
    rot_valid_d = rot_valid_q;
    rot_last_d  = rot_last_q;
    load_row    = 1'b0;
    row_k       = '0;

    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          byte_buf_d[byte_cnt_q] = in_byte;
          if (byte_cnt_q == LastIdx) begin
            byte_cnt_d  = '0;
            state_d     = StEmit;
            load_row    = 1'b1;
            row_k       = '0;
            rot_cnt_d   = '0;
            rot_valid_d = 1'b1;
            rot_last_d  = (COLUMN == 1);
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      StEmit: begin
        if (rot_valid_q && rot_ready) begin
          if (rot_cnt_q == LastIdx) begin
            state_d     = StLoad;
            rot_valid_d = 1'b0;
            rot_last_d  = 1'b0;
            rot_cnt_d   = '0;
          end else begin
            load_row   = 1'b1;
            row_k      = rot_cnt_q + 1'b1;
            rot_cnt_d  = row_k;
            rot_last_d = (row_k == LastIdx);
          end
        end
      end
      default: begin
        state_d     = StLoad;
        byte_cnt_d  = '0;
        rot_cnt_d   = '0;
        rot_valid_d = 1'b0;
        rot_last_d  = 1'b0;
      end
    endcase
  end

  // Row mux: element j of rotation k is character (j + k) mod COLUMN.
  for (genvar j = 0; j < COLUMN; j++) begin : g_row
    logic [IDX_W-1:0] src_idx;
    assign src_idx      = IDX_W'(rot_idx(j, 32'(row_k), COLUMN));
    assign rot_row_d[j] = load_row ? byte_buf_d[src_idx] : rot_row_q[j];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      byte_cnt_q  <= '0;
      rot_cnt_q   <= '0;
      rot_row_q   <= '{default: '0};
      rot_valid_q <= 1'b0;
      rot_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      rot_cnt_q   <= rot_cnt_d;
      rot_row_q   <= rot_row_d;
      rot_valid_q <= rot_valid_d;
      rot_last_q  <= rot_last_d;
    end
  end

  // Buffer contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    byte_buf_q <= byte_buf_d;
  end

  assign in_ready  = (state_q == StLoad);
  assign busy      = (state_q == StEmit);
  assign rot_row   = rot_row_q;
  assign rot_valid = rot_valid_q;
  assign rot_index = rot_cnt_q;
  assign rot_last  = rot_last_q;

endmodule

// File: doc/bwt_rotation_gen.md
Name: bwt_rotation_gen

Overview:
Upstream feeder of the BWT sort stage. It captures one input block of COLUMN bytes, then emits all COLUMN cyclic rotations of that block, one row per handshake. Each row is an array of COLUMN bytes and is written into the row FIFO that the two-element comparator/sorter reads. Loading and emitting never overlap; the block alternates between the two phases.

Parameters:
COLUMN, 3, bytes per block, which is also the number of rotations emitted per block; legal range >= 2.
IDX_W, $clog2(COLUMN) (min 1), width of the byte and rotation counters.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
in_valid  in  1  input byte valid
in_byte  in  8  input byte; the first byte of a block is character 0
in_ready  out  1  block can accept a byte
rot_row  out  8 x [COLUMN-1:0] (unpacked)  rotation row; element j = character j of the rotation
rot_valid  out  1  rot_row is valid
rot_ready  in  1  downstream FIFO not full / accepts the row
rot_index  out  IDX_W  rotation number k of the current row
rot_last  out  1  high with the row for k = COLUMN-1
busy  out  1  high in the EMIT state

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state = LOAD, byte counter = 0, rotation counter = 0.
  - rot_row = all 8'h00, rot_valid = 0, rot_index = 0, rot_last = 0, busy = 0.
  - Byte buffer contents are don't-care.
- Reset applied mid-operation discards the partial block or partial emission. There is no flush. in_ready = 1 on the cycle after reset.
- State machine has two states, LOAD and EMIT:
  - LOAD: in_ready = 1. A byte is accepted when in_valid && in_ready; it is stored at buf[byte_cnt], then byte_cnt increments.
  - Acceptance of the byte at byte_cnt = COLUMN-1 does three things:
    - byte_cnt returns to 0 and the state goes to EMIT.
    - rot_row is loaded with rotation 0 (buf with the new byte included), rot_index = 0, rot_valid = 1.
    - rot_last = (COLUMN-1 == 0), which is always 0 for legal COLUMN.
  - Latency: the last byte accepted at edge N gives rot_valid = 1 from cycle N+1.
  - EMIT: in_ready = 0 and in_valid is ignored. The buffer is frozen.
  - Row k is defined as rot_row[j] = buf[(j+k) mod COLUMN] for j = 0..COLUMN-1. Wrap is a modulo-COLUMN index and must be correct for non-power-of-2 COLUMN.
  - A transfer occurs when rot_valid && rot_ready.
    - If k < COLUMN-1: on the next edge the registers take row k+1, rot_index = k+1, and rot_last = (k+1 == COLUMN-1).
    - If k = COLUMN-1: on the next edge state = LOAD, rot_valid = 0, rot_last = 0, rot_index = 0. rot_row holds its last value (don't-care while not valid).
  - Backpressure: while rot_valid && !rot_ready, rot_row, rot_index and rot_last hold stable.
- rot_valid is never deasserted without a transfer, except by reset.
- Throughput:
  - One row per cycle under continuous rot_ready.
  - A full block takes COLUMN load cycles plus COLUMN emit cycles. There is no bubble between the last transfer and the first in_ready of the next block, since in_ready rises the cycle after that transfer.
- All outputs come from registers. in_ready and busy are decoded directly from the state register.
- Unused state encodings go to LOAD with counters cleared.

Decomposition:
- Shared package bwt_pkg holds:
  - BYTE_W = 8
  - the state enum (LOAD, EMIT)
  - a function rot_idx(j, k, COLUMN) that returns (j+k) mod COLUMN without a divider (compare-and-subtract, since j, k < COLUMN).
- No sub-module. Buffer, FSM and row mux live in this block. The row build is a generate loop over j using rot_idx.

Test Plan:
1. COLUMN=3, bytes 61,62,63 with rot_ready=1 -> rows [61,62,63], [62,63,61], [63,61,62] on consecutive cycles; rot_index 0,1,2; rot_last only on the third row; in_ready=1 on the cycle after.
2. Same block, rot_ready low for 3 cycles while row 1 is valid -> rot_row stays [62,63,61] and rot_index stays 1 throughout; row 2 appears only after rot_ready rises.
3. in_valid toggled with gaps (61, idle, 62, idle, idle, 63) -> identical rows to scenario 1; rot_valid rises exactly one cycle after the byte 63 is accepted.
4. in_valid=1 with byte FF held during EMIT -> FF is never stored; the next block starts clean after row 2 transfers.
5. rst asserted while row 1 is pending -> next cycle rot_valid=0, busy=0, in_ready=1; a new block 01,02,03 then yields [01,02,03], [02,03,01], [03,01,02].
6. COLUMN=5, bytes 10..14, back-to-back with a second block 20..24 -> 5 correctly wrapped rows per block (e.g. k=4: [14,10,11,12,13]); rot_last on every fifth row; no lost or duplicated rows.
